// File: rtl/sort_feeder.sv
// sort_feeder: source stage for the insertion-sort cell chain.
// Each invocation moves LEN words from the source FIFO to the first cell,
// then appends FLUSH_CNT sentinels so every cell drains its retained value.
// Control follows the ap_ctrl_chain handshake with start propagation.
//
// FIFO handshake: a word moves on a cycle where the producer side shows data
// (src_V_empty_n = 1) and the consumer side shows space (out_V_full_n = 1);
// src_V_read and out_V_write are asserted together only in such a cycle, and
// out_V_din is valid only while out_V_write is high.
module sort_feeder #(
    parameter int                DATA_W    = 32,
    parameter int                LEN       = 8,
    parameter int                FLUSH_CNT = 8,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {1'b0, {(DATA_W-1){1'b1}}}
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic              start_full_n,
    output logic              start_out,
    output logic              start_write,
    input  logic [DATA_W-1:0] src_V_dout,
    input  logic              src_V_empty_n,
    output logic              src_V_read,
    output logic [DATA_W-1:0] out_V_din,
    input  logic              out_V_full_n,
    output logic              out_V_write
);

    localparam int MAX_CNT = (LEN > FLUSH_CNT) ? LEN : FLUSH_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             start_once_reg;
    logic             ap_done_reg;
    logic             real_start;
    logic             final_write;

    // A start counts only once the downstream start FIFO can take the token,
    // or once the token for this invocation has already been pushed.
    assign real_start  = ap_start & (start_once_reg | start_full_n);
    assign start_out   = real_start;
    // Gated by reset so no start token is pushed while the block is held in reset.
    assign start_write = ap_rst_n & real_start & ~start_once_reg;
    assign ap_ready    = final_write;
    assign ap_done     = final_write | ap_done_reg;

    // State and word counter register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Start token bookkeeping and done hold until the caller acknowledges.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            start_once_reg <= 1'b0;
            ap_done_reg    <= 1'b0;
        end else begin
            if (ap_ready) begin
                start_once_reg <= 1'b0;
            end else if (real_start) begin
                start_once_reg <= 1'b1;
            end
            if (ap_continue) begin
                ap_done_reg <= 1'b0;
            end else if (final_write) begin
                ap_done_reg <= 1'b1;
            end
        end
    end

    // Next-state, counter and FIFO strobes; data passes through unregistered.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        src_V_read  = 1'b0;
        out_V_write = 1'b0;
        out_V_din   = '0;
        final_write = 1'b0;
        ap_idle     = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = ~real_start;
                if (real_start && !ap_done_reg) begin
                    state_next = FEED;
                    cnt_next   = '0;
                end
            end
            FEED: begin
                out_V_din = src_V_dout;
                if (src_V_empty_n && out_V_full_n) begin
                    src_V_read  = 1'b1;
                    out_V_write = 1'b1;
                    if (cnt == LAST_FEED) begin
                        state_next = FLUSH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                out_V_din = FLUSH_VAL;
                if (out_V_full_n) begin
                    out_V_write = 1'b1;
                    if (cnt == LAST_FLUSH) begin
                        final_write = 1'b1;
                        state_next  = IDLE;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sort_feeder.sv
// Testbench for sort_feeder with LEN = FLUSH_CNT = 4.
// Inputs change 2 time units after the rising edge; outputs are sampled on
// the falling edge. A source FIFO model feeds the block and every word
// written to the output is popped from exp_q and compared.
module tb_sort_feeder;

    localparam int                DATA_W    = 32;
    localparam int                LEN       = 4;
    localparam int                FLUSH_CNT = 4;
    localparam logic [DATA_W-1:0] FLUSH_VAL = 32'h7FFF_FFFF;

    logic              ap_clk        = 1'b0;
    logic              ap_rst_n      = 1'b0;
    logic              ap_start      = 1'b0;
    logic              ap_continue   = 1'b1;
    logic              start_full_n  = 1'b1;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic              start_out;
    logic              start_write;
    logic [DATA_W-1:0] src_V_dout    = '0;
    logic              src_V_empty_n = 1'b0;
    logic              src_V_read;
    logic [DATA_W-1:0] out_V_din;
    logic              out_V_full_n  = 1'b1;
    logic              out_V_write;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              src_stall = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int sw_cnt   = 0;
    int done_cnt = 0;
    int rdy_cnt  = 0;

    sort_feeder #(
        .DATA_W   (DATA_W),
        .LEN      (LEN),
        .FLUSH_CNT(FLUSH_CNT),
        .FLUSH_VAL(FLUSH_VAL)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .start_full_n (start_full_n),
        .start_out    (start_out),
        .start_write  (start_write),
        .src_V_dout   (src_V_dout),
        .src_V_empty_n(src_V_empty_n),
        .src_V_read   (src_V_read),
        .out_V_din    (out_V_din),
        .out_V_full_n (out_V_full_n),
        .out_V_write  (out_V_write)
    );

    // ---------------- clock ----------------
    always #5 ap_clk = ~ap_clk;

    // ---------------- source FIFO model ----------------
    task automatic src_model();
        logic rd;
        forever begin
            @(posedge ap_clk);
            rd = src_V_read;
            #1;
            if (rd && src_q.size() > 0) void'(src_q.pop_front());
            src_V_empty_n = (src_q.size() > 0) && !src_stall;
            src_V_dout    = (src_q.size() > 0) ? src_q[0] : '0;
            #2;
            src_V_empty_n = (src_q.size() > 0) && !src_stall;
            src_V_dout    = (src_q.size() > 0) ? src_q[0] : '0;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        logic [DATA_W-1:0] exp_v;
        forever begin
            @(negedge ap_clk);
            if (out_V_write === 1'b1) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_data got %0h want no write", out_V_din);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_V_din !== exp_v) begin
                        errors++;
                        $display("FAIL out_data got %0h want %0h", out_V_din, exp_v);
                    end
                end
            end
            if (src_V_read === 1'b1)  rd_cnt++;
            if (start_write === 1'b1) sw_cnt++;
            if (ap_done === 1'b1)     done_cnt++;
            if (ap_ready === 1'b1)    rdy_cnt++;
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic push_run(input logic [DATA_W-1:0] w0, w1, w2, w3);
        src_q.push_back(w0); src_q.push_back(w1); src_q.push_back(w2); src_q.push_back(w3);
        exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
        for (int k = 0; k < FLUSH_CNT; k++) exp_q.push_back(FLUSH_VAL);
    endtask

    // Waits (bounded) for the ap_ready cycle, then drops ap_start after that edge.
    task automatic wait_ready_drop(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (ap_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge ap_clk); #2;
        ap_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; start_full_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        checks++; if (ap_done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", ap_done); end
        checks++; if (ap_ready !== 1'b0)    begin errors++; $display("FAIL reset_ready got %b want 0", ap_ready); end
        checks++; if (src_V_read !== 1'b0)  begin errors++; $display("FAIL reset_read got %b want 0", src_V_read); end
        checks++; if (out_V_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", out_V_write); end
        checks++; if (out_V_din !== '0)     begin errors++; $display("FAIL reset_din got %0h want 0", out_V_din); end
        checks++; if (ap_idle !== 1'b1)     begin errors++; $display("FAIL reset_idle got %b want 1", ap_idle); end
        ap_start = 1'b1;
        #1;
        checks++; if (ap_idle !== 1'b0)     begin errors++; $display("FAIL reset_idle_start got %b want 0", ap_idle); end
        checks++; if (start_write !== 1'b0) begin errors++; $display("FAIL reset_start_write got %b want 0", start_write); end
        start_full_n = 1'b0;
        #1;
        checks++; if (ap_idle !== 1'b1)     begin errors++; $display("FAIL reset_idle_full got %b want 1", ap_idle); end
        ap_start = 1'b0; start_full_n = 1'b1;
        @(posedge ap_clk); #2;
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk); #2;
    endtask

    task automatic test_basic();
        int wr0, rd0, sw0, dn0, rdy0, lat;
        bit ok;
        wr0 = wr_cnt; rd0 = rd_cnt; sw0 = sw_cnt; dn0 = done_cnt; rdy0 = rdy_cnt;
        push_run(32'd5, 32'hFFFF_FFFD, 32'd9, 32'd1);   // 5, -3, 9, 1
        ap_continue = 1'b1; ap_start = 1'b1;
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin ok = 1'b1; lat = i; break; end
        end
        checks++; if (!ok)               begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
        checks++; if (ap_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_with_done got %b want 1", ap_ready); end
        checks++; if (lat != LEN + FLUSH_CNT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LEN + FLUSH_CNT); end
        @(posedge ap_clk); #2;
        ap_start = 1'b0;
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (wr_cnt - wr0 != 8)   begin errors++; $display("FAIL basic_writes got %0d want 8", wr_cnt - wr0); end
        checks++; if (rd_cnt - rd0 != 4)   begin errors++; $display("FAIL basic_reads got %0d want 4", rd_cnt - rd0); end
        checks++; if (sw_cnt - sw0 != 1)   begin errors++; $display("FAIL basic_start_write got %0d want 1", sw_cnt - sw0); end
        checks++; if (done_cnt - dn0 != 1) begin errors++; $display("FAIL basic_done_cycles got %0d want 1", done_cnt - dn0); end
        checks++; if (rdy_cnt - rdy0 != 1) begin errors++; $display("FAIL basic_ready_cycles got %0d want 1", rdy_cnt - rdy0); end
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL basic_leftover got %0d want 0", exp_q.size()); end
        checks++; if (ap_idle !== 1'b1)    begin errors++; $display("FAIL basic_idle_after got %b want 1", ap_idle); end
    endtask

    task automatic test_src_stall();
        int wr0, rd0, stall_left;
        bit ok, stall_done;
        wr0 = wr_cnt; rd0 = rd_cnt; stall_left = 0; stall_done = 1'b0; ok = 1'b0;
        push_run(32'd7, 32'hFFFF_FF9C, 32'd0, 32'd42);  // 7, -100, 0, 42
        ap_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (stall_left > 0) begin
                checks++;
                if (out_V_write !== 1'b0 || src_V_read !== 1'b0) begin
                    errors++;
                    $display("FAIL src_stall_strobe got wr=%b rd=%b want 0 0", out_V_write, src_V_read);
                end
                stall_left--;
            end
            if (ap_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge ap_clk); #2;
            if (!stall_done && rd_cnt - rd0 == 2) begin
                src_stall = 1'b1; stall_left = 3; stall_done = 1'b1;
            end else if (stall_left == 0) begin
                src_stall = 1'b0;
            end
        end
        @(posedge ap_clk); #2;
        ap_start = 1'b0; src_stall = 1'b0;
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (!ok || !stall_done) begin errors++; $display("FAIL src_stall_timeout got ok=%b stall=%b want 1 1", ok, stall_done); end
        checks++; if (wr_cnt - wr0 != 8)  begin errors++; $display("FAIL src_stall_writes got %0d want 8", wr_cnt - wr0); end
        checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL src_stall_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_out_backpressure();
        int wr0, full_left, stage;
        bit ok;
        wr0 = wr_cnt; full_left = 0; stage = 0; ok = 1'b0;
        // -1, the sentinel value as data, the most negative value, 3
        push_run(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd3);
        ap_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (full_left > 0) begin
                checks++;
                if (out_V_write !== 1'b0 || src_V_read !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_strobe got wr=%b rd=%b want 0 0", out_V_write, src_V_read);
                end
                full_left--;
            end
            if (ap_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge ap_clk); #2;
            if (full_left == 0) out_V_full_n = 1'b1;
            if (stage == 0 && wr_cnt - wr0 == 1) begin
                out_V_full_n = 1'b0; full_left = 2; stage = 1;
            end else if (stage == 1 && wr_cnt - wr0 == 5) begin
                out_V_full_n = 1'b0; full_left = 2; stage = 2;
            end
        end
        @(posedge ap_clk); #2;
        ap_start = 1'b0; out_V_full_n = 1'b1;
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (!ok || stage != 2) begin errors++; $display("FAIL backpressure_timeout got ok=%b stage=%0d want 1 2", ok, stage); end
        checks++; if (wr_cnt - wr0 != 8) begin errors++; $display("FAIL backpressure_writes got %0d want 8", wr_cnt - wr0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL backpressure_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_done_hold();
        int wr0, rd0, sw0;
        bit ok;
        wr0 = wr_cnt; rd0 = rd_cnt; sw0 = sw_cnt; ok = 1'b0;
        push_run(32'd1, 32'd2, 32'd3, 32'd4);
        push_run(32'd10, 32'd20, 32'd30, 32'd40);
        ap_continue = 1'b0; ap_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL hold_first_done_timeout got 0 want 1"); end
        repeat (5) begin
            @(negedge ap_clk);
            checks++;
            if (ap_done !== 1'b1 || src_V_read !== 1'b0 || out_V_write !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle got done=%b rd=%b wr=%b want 1 0 0", ap_done, src_V_read, out_V_write);
            end
        end
        @(posedge ap_clk); #2;
        checks++; if (rd_cnt - rd0 != 4) begin errors++; $display("FAIL hold_reads got %0d want 4", rd_cnt - rd0); end
        ap_continue = 1'b1;
        @(posedge ap_clk); #2;
        ap_continue = 1'b0;
        wait_ready_drop(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_second_timeout got 0 want 1"); end
        @(negedge ap_clk);
        checks++; if (ap_done !== 1'b1) begin errors++; $display("FAIL hold_second_done got %b want 1", ap_done); end
        @(posedge ap_clk); #2;
        ap_continue = 1'b1;
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (ap_done !== 1'b0)    begin errors++; $display("FAIL hold_cleared got %b want 0", ap_done); end
        checks++; if (wr_cnt - wr0 != 16)  begin errors++; $display("FAIL hold_writes got %0d want 16", wr_cnt - wr0); end
        checks++; if (sw_cnt - sw0 != 2)   begin errors++; $display("FAIL hold_start_write got %0d want 2", sw_cnt - sw0); end
        checks++; if (exp_q.size() != 0)   begin errors++; $display("FAIL hold_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_start_full();
        int wr0, sw0;
        bit ok;
        wr0 = wr_cnt; sw0 = sw_cnt;
        push_run(32'd100, 32'hFFFF_FFF6, 32'd55, 32'd0);  // 100, -10, 55, 0
        start_full_n = 1'b0; ap_start = 1'b1; ap_continue = 1'b1;
        repeat (4) begin
            @(negedge ap_clk);
            checks++;
            if (ap_idle !== 1'b1 || src_V_read !== 1'b0 || start_write !== 1'b0 || start_out !== 1'b0) begin
                errors++;
                $display("FAIL start_full_blocked got idle=%b rd=%b sw=%b so=%b want 1 0 0 0",
                         ap_idle, src_V_read, start_write, start_out);
            end
        end
        @(posedge ap_clk); #2;
        start_full_n = 1'b1;
        wait_ready_drop(ok);
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (!ok)               begin errors++; $display("FAIL start_full_timeout got 0 want 1"); end
        checks++; if (sw_cnt - sw0 != 1) begin errors++; $display("FAIL start_full_start_write got %0d want 1", sw_cnt - sw0); end
        checks++; if (wr_cnt - wr0 != 8) begin errors++; $display("FAIL start_full_writes got %0d want 8", wr_cnt - wr0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL start_full_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int wr0, rd0, dn0;
        bit ok;
        wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; ok = 1'b0;
        push_run($urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 1000));
        ap_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ap_clk);
            @(posedge ap_clk); #2;
            if (rd_cnt - rd0 == 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid_timeout got 0 want 1"); end
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (out_V_write !== 1'b0 || src_V_read !== 1'b0 || ap_done !== 1'b0 || ap_ready !== 1'b0
            || start_write !== 1'b0 || out_V_din !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got wr=%b rd=%b done=%b rdy=%b sw=%b din=%0h want all 0",
                     out_V_write, src_V_read, ap_done, ap_ready, start_write, out_V_din);
        end
        checks++; if (wr_cnt - wr0 != 2) begin errors++; $display("FAIL reset_mid_pre_writes got %0d want 2", wr_cnt - wr0); end
        src_q.delete();
        exp_q.delete();
        repeat (2) @(posedge ap_clk); #2;
        checks++; if (wr_cnt - wr0 != 2 || done_cnt != dn0) begin
            errors++; $display("FAIL reset_mid_quiet got wr=%0d done=%0d want 2 0", wr_cnt - wr0, done_cnt - dn0);
        end
        push_run(32'd8, 32'hFFFF_FFF8, 32'd16, 32'd2);  // 8, -8, 16, 2
        wr0 = wr_cnt; rd0 = rd_cnt;
        ap_rst_n = 1'b1;
        wait_ready_drop(ok);
        repeat (3) @(posedge ap_clk); #2;
        checks++; if (!ok)               begin errors++; $display("FAIL reset_mid_rerun_timeout got 0 want 1"); end
        checks++; if (wr_cnt - wr0 != 8) begin errors++; $display("FAIL reset_mid_rerun_writes got %0d want 8", wr_cnt - wr0); end
        checks++; if (rd_cnt - rd0 != 4) begin errors++; $display("FAIL reset_mid_rerun_reads got %0d want 4", rd_cnt - rd0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_leftover got %0d want 0", exp_q.size()); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        fork
            src_model();
            monitor();
        join_none
        test_reset();
        test_basic();
        test_src_stall();
        test_out_backpressure();
        test_done_hold();
        test_start_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
